neo_busctl: RTL and testbench
=============================

# neo_busctl

Parametrised 68k bus controller for the NeoGeo core: decodes `ZONES` address windows and generates `nDTACK` per access from per-zone wait counts, which are runtime-reprogrammable. Per-zone external wait inputs can stretch a cycle further. A watchdog raises `nBERR` on stalled or unmapped cycles. It sits between the TG68k bus and the chip-select consumers, replacing fixed decode/wait logic. It runs on the system clock, with 68k-rate advancement gated by `CLK_EN_68K_P`.

## Interface
Parameters:
- `ZONES`, 4: number of decoded zones; 1..16.
- `AW`, 7: compared address bits, `M68K_ADDR[23:24-AW]`.
- `WAIT_W`, 3: width of each wait count.
- `ZONE_BASE`, {AW{1'b0}} x ZONES: packed `ZONES*AW` match values; zone i occupies bits `[i*AW +: AW]`.
- `ZONE_MASK`, {AW{1'b1}} x ZONES: packed compare masks. A 1 bit is compared.
- `ZONE_WAIT`, 0 x ZONES: packed `ZONES*WAIT_W` reset wait counts.
- `ZONE_EXTW`, 0: `ZONES`-bit mask. Bit i set means zone i honours `nEXTWAIT[i]`.
- `TIMEOUT`, 64: 68k enables before bus error; 0 disables the watchdog.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `CLK_EN_68K_P` in 1: 68k clock-enable pulse; every state advance requires it.
- `M68K_ADDR` in AW: upper address bits.
- `nAS`, `RW`, `nLDS`, `nUDS` in 1 each: 68k strobes.
- `nEXTWAIT` in ZONES: per-zone external wait, active low.
- `CFG_WE` in 1: write a wait count.
- `CFG_SEL` in 4: zone index for `CFG_WE`; values >= ZONES are ignored.
- `CFG_DATA` in WAIT_W: new wait count.
- `nZONE` out ZONES: combinational one-hot-low chip selects.
- `nDTACK` out 1: registered acknowledge.
- `nBERR` out 1: registered bus error.
- `ZONE_ID` out 4: registered index of the latched zone.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- Hit(i) = `((M68K_ADDR ^ base_i) & mask_i) == 0`. The lowest index wins on overlap.
- `nZONE[i]` = 0 only when hit(i) is the winner, `nAS`=0, and (`nLDS`=0 or `nUDS`=0).
- `wait_reg[i]` resets to `ZONE_WAIT[i]`. When `CFG_WE`=1 and `CFG_SEL`<ZONES, `wait_reg[CFG_SEL]` takes `CFG_DATA` on the CLK edge, whether or not `CLK_EN_68K_P` is asserted.
- `blk` = `ZONE_EXTW[z]` & ~`nEXTWAIT[z]`, where z is the latched zone.

States (all transitions require `CLK_EN_68K_P`=1, except the asynchronous reset):
- **IDLE**
  - `nAS`=1: stay.
  - `nAS`=0, no hit: go to UNMAP.
  - `nAS`=0, hit: latch z into `ZONE_ID` and W=`wait_reg[z]`.
    - W=0 and !blk: go to ACK.
    - W=0 and blk: go to EXT.
    - W>0: go to COUNT with cnt=W-1.
- **COUNT**
  - cnt≠0: decrement cnt.
  - cnt=0 and blk: go to EXT.
  - cnt=0 and !blk: go to ACK.
- **EXT**: !blk: go to ACK. Otherwise stay.
- **ACK**: `nDTACK`=0. `nAS`=1: go to IDLE, and `nDTACK` returns to 1 on the same edge.
- **BERR**: `nBERR`=0. `nAS`=1: go to IDLE.
- **UNMAP**: waits for the watchdog.
- **Abort rule**: `nAS`=1 observed in COUNT, EXT or UNMAP returns the block to IDLE with no acknowledge.
- **Watchdog**
  - `tmr` clears in IDLE.
  - It increments on each enable in COUNT, EXT or UNMAP.
  - When `TIMEOUT`>0 and `tmr`=TIMEOUT-1 on an enable edge, the block goes to BERR. This transition takes priority over the ACK transition on the same edge.
  - Width: clog2(TIMEOUT+1).
- Same-edge rules:
  - A `CFG_WE` on the same edge as an IDLE load means the load uses the old value.
  - The latched W is unaffected by later writes.

## Timing
- Reset values:
  - `nDTACK`=1, `nBERR`=1, `ZONE_ID`=0, `BUSY`=0.
  - State is IDLE, cnt=0, `tmr`=0.
  - `wait_reg` takes the `ZONE_WAIT` parameter values.
  - `nZONE` is combinational and follows its inputs.
- Latency: `nAS` sampled low at enable edge k with W waits and no blk gives `nDTACK`=0 after edge k+W.
- blk adds one enable edge per enable during which it is held, counted after the wait expires.
- `nDTACK` deasserts on the first enable edge that samples `nAS`=1.
- `RESET` mid-cycle: outputs go to their reset values immediately (asynchronous). After release, the FSM re-evaluates `nAS` from IDLE.
- No state change occurs when `CLK_EN_68K_P`=0.

## Test plan
- **Zero-wait decode**: ZONE_BASE zone0=7'h00, mask 7'h78, W0=0. Drive `nAS`=0 at enable k with A=0x000000 → `nZONE`=4'b1110 combinationally; `nDTACK`=0 after edge k; `nAS`=1 → `nDTACK`=1 next enable.
- **Wait states**: set W1=3 via `CFG_WE`, then access zone 1 → `nDTACK` falls at edge k+3 and `BUSY`=1 from edge k. Repeat with `CFG_WE` on the same edge as k → the old count is used.
- **External wait**: `ZONE_EXTW`[2]=1, W2=1, `nEXTWAIT[2]` low for 5 enables → ACK at edge k+1+5; `ZONE_ID`=2.
- **Unmapped access**: TIMEOUT=8, address outside all zones → `nBERR`=0 after edge k+8; `nDTACK` stays 1; `nAS`=1 → IDLE.
- **Watchdog vs ack**: zone with W=7, TIMEOUT=7 → `nBERR` wins; with TIMEOUT=0 → `nDTACK` at k+7.
- **Reset/abort**: assert `RESET` in COUNT → `nDTACK`/`nBERR`=1 and `BUSY`=0 immediately. Raising `nAS` during EXT → IDLE with no ack. Gaps in `CLK_EN_68K_P` → no state advance.

Source files
------------

// File: rtl/neo_busctl.sv
// 68k bus controller: windowed zone decode, runtime-programmable per-zone wait
// states, external wait stretching and a bus-error watchdog.
module neo_busctl #(
    parameter int                       ZONES     = 4,
    parameter int                       AW        = 7,
    parameter int                       WAIT_W    = 3,
    parameter logic [ZONES*AW-1:0]      ZONE_BASE = '0,
    parameter logic [ZONES*AW-1:0]      ZONE_MASK = '1,
    parameter logic [ZONES*WAIT_W-1:0]  ZONE_WAIT = '0,
    parameter logic [ZONES-1:0]         ZONE_EXTW = '0,
    parameter int                       TIMEOUT   = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLK_EN_68K_P,
    input  logic [AW-1:0]     M68K_ADDR,
    input  logic              nAS,
    input  logic              RW,
    input  logic              nLDS,
    input  logic              nUDS,
    input  logic [ZONES-1:0]  nEXTWAIT,
    input  logic              CFG_WE,
    input  logic [3:0]        CFG_SEL,
    input  logic [WAIT_W-1:0] CFG_DATA,
    output logic [ZONES-1:0]  nZONE,
    output logic              nDTACK,
    output logic              nBERR,
    output logic [3:0]        ZONE_ID,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_EXT, S_ACK, S_BERR, S_UNMAP
    } state_t;

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait [ZONES];
    logic [WAIT_W-1:0] r_cnt, w_cnt_nx, w_wait;
    logic [TW-1:0]     r_tmr, w_tmr_nx;
    logic [3:0]        r_zone, w_hit_zone, w_cur_zone;
    logic              w_hit, w_blk, w_wd, w_load;
    logic              r_ndtack, r_nberr;
    logic [ZONES-1:0]  w_nzone;
    logic              w_unused;

    assign w_unused = RW;

    always_comb begin
        w_hit      = 1'b0;
        w_hit_zone = '0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            if (!w_hit && ((M68K_ADDR ^ ZONE_BASE[i*AW +: AW]) & ZONE_MASK[i*AW +: AW]) == '0) begin
                w_hit      = 1'b1;
                w_hit_zone = 4'(i);
            end
        end
    end

    always_comb begin
        w_nzone = '1;
        for (int unsigned i = 0; i < ZONES; i++) begin
            if (w_hit && w_hit_zone == 4'(i) && !nAS && (!nLDS || !nUDS))
                w_nzone[i] = 1'b0;
        end
    end

    // In IDLE the zone being latched this edge drives wait/blk; afterwards the held one.
    assign w_cur_zone = (r_state == S_IDLE) ? w_hit_zone : r_zone;

    always_comb begin
        w_wait = '0;
        w_blk  = 1'b0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            if (w_cur_zone == 4'(i)) begin
                w_wait = r_wait[i];
                w_blk  = ZONE_EXTW[i] & ~nEXTWAIT[i];
            end
        end
    end

    assign w_wd = (TIMEOUT > 0) && (r_tmr == TMR_LAST);

    always_comb begin
        w_next   = r_state;
        w_cnt_nx = r_cnt;
        w_tmr_nx = r_tmr;
        w_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tmr_nx = '0;
                if (!nAS) begin
                    if (!w_hit) begin
                        w_next = S_UNMAP;
                    end else begin
                        w_load = 1'b1;
                        if (w_wait == '0) begin
                            w_next = w_blk ? S_EXT : S_ACK;
                        end else begin
                            w_next   = S_COUNT;
                            w_cnt_nx = w_wait - 1'b1;
                        end
                    end
                end
            end
            S_COUNT: begin
                w_tmr_nx = r_tmr + 1'b1;
                if (nAS)                w_next = S_IDLE;
                else if (w_wd)          w_next = S_BERR;
                else if (r_cnt != '0)   w_cnt_nx = r_cnt - 1'b1;
                else                    w_next = w_blk ? S_EXT : S_ACK;
            end
            S_EXT: begin
                w_tmr_nx = r_tmr + 1'b1;
                if (nAS)                w_next = S_IDLE;
                else if (w_wd)          w_next = S_BERR;
                else if (!w_blk)        w_next = S_ACK;
            end
            S_UNMAP: begin
                w_tmr_nx = r_tmr + 1'b1;
                if (nAS)                w_next = S_IDLE;
                else if (w_wd)          w_next = S_BERR;
            end
            S_ACK, S_BERR: begin
                if (nAS)                w_next = S_IDLE;
            end
            default:                    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_tmr    <= '0;
            r_zone   <= '0;
            r_ndtack <= 1'b1;
            r_nberr  <= 1'b1;
        end else if (CLK_EN_68K_P) begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nx;
            r_tmr    <= w_tmr_nx;
            if (w_load)
                r_zone <= w_hit_zone;
            r_ndtack <= (w_next != S_ACK);
            r_nberr  <= (w_next != S_BERR);
        end
    end

    // Config writes are independent of the 68k enable; a same-edge load sees the old count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < ZONES; i++)
                r_wait[i] <= ZONE_WAIT[i*WAIT_W +: WAIT_W];
        end else if (CFG_WE) begin
            for (int unsigned i = 0; i < ZONES; i++)
                if (CFG_SEL == 4'(i))
                    r_wait[i] <= CFG_DATA;
        end
    end

    assign nZONE   = w_nzone;
    assign nDTACK  = r_ndtack;
    assign nBERR   = r_nberr;
    assign ZONE_ID = r_zone;
    assign BUSY    = (r_state != S_IDLE);

endmodule

// File: tb/tb_neo_busctl.sv
// Bench for neo_busctl: three instances differing only in TIMEOUT (8, 7, 0) share
// stimulus; an elapsed-enable model is compared every cycle, plus literal checks.
module tb_neo_busctl;

    localparam int          ZN   = 4;
    localparam logic [27:0] BASE = {7'h20, 7'h20, 7'h08, 7'h00};
    localparam logic [27:0] MASK = {7'h70, 7'h78, 7'h78, 7'h78};
    localparam logic [11:0] WRST = {3'd2, 3'd1, 3'd1, 3'd0};
    localparam logic [3:0]  EXTW = 4'b0100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [6:0] addr = '0;
    logic       nas = 1'b1, rw = 1'b1, nlds = 1'b1, nuds = 1'b1;
    logic [3:0] next = 4'hF;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_sel = '0;
    logic [2:0] cfg_data = '0;

    logic [3:0] nzone [3];
    logic [2:0] ndtack, nberr, busy;
    logic [3:0] zid [3];

    int n_total = 0;
    int n_pass  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        neo_busctl #(
            .ZONES(ZN), .AW(7), .WAIT_W(3),
            .ZONE_BASE(BASE), .ZONE_MASK(MASK), .ZONE_WAIT(WRST), .ZONE_EXTW(EXTW),
            .TIMEOUT(g == 0 ? 8 : (g == 1 ? 7 : 0))
        ) u_dut (
            .CLK(clk), .RESET(rst), .CLK_EN_68K_P(en), .M68K_ADDR(addr),
            .nAS(nas), .RW(rw), .nLDS(nlds), .nUDS(nuds), .nEXTWAIT(next),
            .CFG_WE(cfg_we), .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data),
            .nZONE(nzone[g]), .nDTACK(ndtack[g]), .nBERR(nberr[g]),
            .ZONE_ID(zid[g]), .BUSY(busy[g])
        );
    end

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int j, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, j, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 waiting (mapped or not), 2 acknowledged, 3 bus error
    int         m_ph [3];
    int         m_n [3];
    int         m_w [3];
    int         m_zid [3];
    bit         m_map [3];
    logic [2:0] m_wait [4];

    function automatic int zone_of(input logic [6:0] a);
        for (int i = 0; i < ZN; i++)
            if (((a ^ BASE[i*7 +: 7]) & MASK[i*7 +: 7]) == 7'h0) return i;
        return -1;
    endfunction

    function automatic bit blk_of(input int z);
        return EXTW[z] && !next[z];
    endfunction

    function automatic int to_of(input int j);
        case (j)
            0: return 8;
            1: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_nzone();
        int z;
        z = zone_of(addr);
        if (z >= 0 && !nas && (!nlds || !nuds)) return 4'hF & ~(4'b0001 << z);
        return 4'hF;
    endfunction

    task automatic model_step(input int j);
        int z;
        z = zone_of(addr);
        case (m_ph[j])
            0: if (!nas) begin
                m_n[j] = 0;
                if (z < 0) begin
                    m_map[j] = 1'b0;
                    m_ph[j]  = 1;
                end else begin
                    m_map[j] = 1'b1;
                    m_zid[j] = z;
                    m_w[j]   = int'(m_wait[z]);
                    m_ph[j]  = (m_w[j] == 0 && !blk_of(z)) ? 2 : 1;
                end
            end
            1: begin
                m_n[j]++;
                if (nas) m_ph[j] = 0;
                else if (to_of(j) > 0 && m_n[j] == to_of(j)) m_ph[j] = 3;
                else if (m_map[j] && m_n[j] >= m_w[j] && !blk_of(m_zid[j])) m_ph[j] = 2;
            end
            default: if (nas) m_ph[j] = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int j = 0; j < 3; j++) begin
                m_ph[j] = 0; m_n[j] = 0; m_zid[j] = 0; m_w[j] = 0; m_map[j] = 1'b0;
            end
            for (int i = 0; i < ZN; i++) m_wait[i] = WRST[i*3 +: 3];
        end else begin
            if (en) for (int j = 0; j < 3; j++) model_step(j);
            if (cfg_we && cfg_sel < 4'd4) m_wait[cfg_sel[1:0]] = cfg_data;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("nDTACK", j, int'(ndtack[j]), int'(m_ph[j] != 2));
            chk("nBERR",  j, int'(nberr[j]),  int'(m_ph[j] != 3));
            chk("BUSY",   j, int'(busy[j]),   int'(m_ph[j] != 0));
            chk("ZONE_ID", j, int'(zid[j]),   m_zid[j]);
            chk("nZONE",  j, int'(nzone[j]),  int'(exp_nzone()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic edge_en(input logic e);
        en = e;
        @(posedge clk);
        #2;
    endtask

    task automatic access(input logic [6:0] a, input int inst, input int ext_n,
                          output int ack_at, output int berr_at);
        ack_at = -1;
        berr_at = -1;
        addr = a; nas = 1'b0; nlds = 1'b0;
        for (int i = 0; i < 40; i++) begin
            next = (i >= 1 && i <= ext_n) ? 4'b1011 : 4'b1111;
            edge_en(1'b1);
            cfg_we = 1'b0;
            if (i == 0) chk("busy_after_k", inst, int'(busy[inst]), 1);
            if (!ndtack[inst]) begin ack_at = i; break; end
            if (!nberr[inst]) begin berr_at = i; break; end
        end
        next = 4'hF;
    endtask

    task automatic release_bus(input int inst);
        nas = 1'b1;
        edge_en(1'b1);
        chk("busy_release", inst, int'(busy[inst]), 0);
        chk("dtack_release", inst, int'(ndtack[inst]), 1);
    endtask

    task automatic cfg(input logic [3:0] sel, input logic [2:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        edge_en(1'b0);
        cfg_we = 1'b0;
    endtask

    int ack, berr;

    initial begin
        edge_en(1'b0);
        edge_en(1'b0);
        chk("rst_dtack", 0, int'(ndtack[0]), 1);
        chk("rst_berr",  0, int'(nberr[0]),  1);
        chk("rst_zid",   0, int'(zid[0]),    0);
        chk("rst_busy",  0, int'(busy[0]),   0);
        rst = 1'b0;

        // zero-wait decode
        addr = 7'h00; nas = 1'b0; nlds = 1'b0;
        #1 chk("nzone_z0", 0, int'(nzone[0]), 4'b1110);
        edge_en(1'b1);
        chk("zw_dtack", 0, int'(ndtack[0]), 0);
        chk("zw_busy",  0, int'(busy[0]),   1);
        release_bus(0);

        // enable gaps: zone1 with reset wait of 1
        addr = 7'h08; nas = 1'b0;
        edge_en(1'b0); edge_en(1'b0);
        chk("gap_idle", 0, int'(busy[0]), 0);
        edge_en(1'b1);
        chk("gap_k_busy", 0, int'(busy[0]), 1);
        edge_en(1'b0); edge_en(1'b0); edge_en(1'b0);
        chk("gap_hold", 0, int'(ndtack[0]), 1);
        edge_en(1'b1);
        chk("gap_ack", 0, int'(ndtack[0]), 0);
        release_bus(0);

        // programmed wait states, then same-edge write uses old count
        cfg(4'd1, 3'd3);
        access(7'h08, 0, 0, ack, berr);
        chk("w3_ack_at", 0, ack, 3);
        release_bus(0);
        cfg_we = 1'b1; cfg_sel = 4'd1; cfg_data = 3'd5;
        access(7'h08, 0, 0, ack, berr);
        chk("same_edge_ack_at", 0, ack, 3);
        release_bus(0);
        access(7'h08, 0, 0, ack, berr);
        chk("w5_ack_at", 0, ack, 5);
        release_bus(0);

        // external wait on zone 2 (overlapping zone 3; lowest index wins)
        access(7'h20, 0, 5, ack, berr);
        chk("ext_ack_at", 0, ack, 6);
        chk("ext_zid", 0, int'(zid[0]), 2);
        release_bus(0);

        // combinational selects: overlap, byte strobes, zone 3 only
        addr = 7'h20; nas = 1'b0; nlds = 1'b1; nuds = 1'b0;
        #1 chk("nzone_ovl", 0, int'(nzone[0]), 4'b1011);
        nuds = 1'b1;
        #1 chk("nzone_nostrobe", 0, int'(nzone[0]), 4'b1111);
        addr = 7'h28; nlds = 1'b0;
        #1 chk("nzone_z3", 0, int'(nzone[0]), 4'b0111);
        nas = 1'b1;

        // unmapped access
        access(7'h7F, 0, 0, ack, berr);
        chk("unmap_berr_at", 0, berr, 8);
        chk("unmap_ack_at", 0, ack, -1);
        chk("unmap_dtack", 0, int'(ndtack[0]), 1);
        release_bus(0);

        // abort during EXT
        addr = 7'h20; nas = 1'b0; next = 4'b1011;
        edge_en(1'b1); edge_en(1'b1); edge_en(1'b1);
        chk("ext_busy", 0, int'(busy[0]), 1);
        nas = 1'b1;
        edge_en(1'b1);
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_dtack", 0, int'(ndtack[0]), 1);
        next = 4'hF;
        edge_en(1'b1);

        // asynchronous reset while counting; wait table returns to defaults
        cfg(4'd1, 3'd5);
        addr = 7'h08; nas = 1'b0;
        edge_en(1'b1); edge_en(1'b1);
        chk("cnt_busy", 0, int'(busy[0]), 1);
        chk("cnt_zid", 0, int'(zid[0]), 1);
        rst = 1'b1;
        #1;
        chk("arst_busy",  0, int'(busy[0]),   0);
        chk("arst_dtack", 0, int'(ndtack[0]), 1);
        chk("arst_berr",  0, int'(nberr[0]),  1);
        chk("arst_zid",   0, int'(zid[0]),    0);
        edge_en(1'b0);
        rst = 1'b0;
        access(7'h08, 0, 0, ack, berr);
        chk("post_rst_ack_at", 0, ack, 1);
        release_bus(0);

        // watchdog vs ack: W=7 on zone 3
        cfg(4'd3, 3'd7);
        access(7'h28, 1, 0, ack, berr);
        chk("wd7_berr_at", 1, berr, 7);
        chk("wd7_dtack", 1, int'(ndtack[1]), 1);
        chk("to0_dtack", 2, int'(ndtack[2]), 0);
        chk("to8_dtack", 0, int'(ndtack[0]), 0);
        release_bus(1);

        // out-of-range config select is ignored
        cfg(4'd12, 3'd0);
        access(7'h28, 2, 0, ack, berr);
        chk("cfgsel_ign_ack_at", 2, ack, 7);
        release_bus(2);

        edge_en(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
